uart_tx_buffered: RTL



---
 rtl/uart_tx_buffered_if.sv | 12 +
 rtl/uart_tx_buffered.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_tx_buffered_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter.
// Bytes are queued in a small FIFO through a valid/ready handshake.
// They are serialised as start / data (LSB first) / stop frames.
// A one-cycle break_req queues a BREAK, which jumps ahead of any queued
// data but never interrupts a frame that is already on the line.
// uart_txd is registered from the current state, so the line follows the
// FSM one cycle late. Every period therefore keeps its exact length, and a
// byte pushed at edge N is popped at N+1 and starts the line at N+2.
module uart_tx_buffered #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int BREAK_BITS   = 11
) (
  input  logic                             clk,
  input  logic                             reset,
  uart_tx_buffered_if.slave                tx_if,
  input  logic                             break_req,
  output logic                             uart_txd,
  output logic                             tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int STOP_CYC = STOP_BITS * CPB;
  localparam int BRK_LOW  = BREAK_BITS * CPB;
  localparam int BRK_CYC  = BRK_LOW + CPB;          // low period plus one mark bit
  localparam int CW       = $clog2(BRK_CYC + 1);    // BREAK is the longest timed state
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int NW       = $clog2(FIFO_DEPTH + 1);
  localparam int BW       = $clog2(PAYLOAD_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]           count_q, count_d;
  logic                    brk_pend_q, brk_pend_d;
  logic                    txd_q, txd_d;
  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];

  logic tx_ready_s;
  logic push_s;
  logic pop_s;
  logic enter_brk_s;

  // A full FIFO refuses data even if a pop frees a slot in the same cycle.
  assign tx_ready_s     = (count_q != NW'(FIFO_DEPTH));
  assign push_s         = tx_if.tx_valid && tx_ready_s;
  assign tx_if.tx_ready = tx_ready_s;
  assign uart_txd       = txd_q;
  assign tx_busy        = (state_q != S_IDLE);
  assign fifo_count     = count_q;

  // Serialiser sequencing: next state, bit/cycle counters, shift register, line level.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pop_s       = 1'b0;
    enter_brk_s = 1'b0;
    txd_d       = 1'b1;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        cyc_d = '0;
        bit_d = '0;
        if (brk_pend_q) begin
          enter_brk_s = 1'b1;
          state_d     = S_BREAK;
        end else if (count_q != '0) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (cyc_q == CW'(CPB - 1)) begin
          cyc_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (cyc_q == CW'(CPB - 1)) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BW'(PAYLOAD_BITS - 1)) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (cyc_q == CW'(STOP_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (cyc_q < CW'(BRK_LOW)) begin
          txd_d = 1'b0;
        end else begin
          txd_d = 1'b1;
        end
        if (cyc_q == CW'(BRK_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        cyc_d   = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointers, occupancy and the break-pending flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    // Requests seen while a break is already pending fold into that one break.
    if (enter_brk_s) begin
      brk_pend_d = 1'b0;
    end else begin
      brk_pend_d = brk_pend_q | break_req;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= tx_if.tx_data;
    end
  end

  // All control state; reset aborts any frame and leaves the line idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      brk_pend_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      brk_pend_q <= brk_pend_d;
      txd_q      <= txd_d;
    end
  end

endmodule
